// File: rtl/pll_clk_monitor.sv
`timescale 1ns/1ps
// Monitors the PLL lock and two PLL output clocks from the clk_tb domain. It counts edges per
// window once lock has settled and raises sticky flags for lock loss and out-of-tolerance counts.
module pll_clk_monitor #(
    parameter int unsigned WINDOW_CYCLES = 1000,
    parameter int unsigned LOCK_SETTLE   = 64,
    parameter int unsigned EXP_CNT2      = 50,
    parameter int unsigned EXP_CNT3      = 100,
    parameter int unsigned TOL           = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk_tb,
    input  logic             rst_n,
    input  logic             meas_en,
    input  logic             clr_err,
    input  logic             pll_lock,
    input  logic             clkout2,
    input  logic             clkout3,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
    output logic             meas_valid,
    output logic             freq_err2,
    output logic             freq_err3,
    output logic             lock_err,
    output logic [1:0]       relock_cnt,
    output logic             err_chk,
    output logic [2:0]       results_cnt,
    output logic [1:0]       state
);

    localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned SET_W = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_SETTLE - 1);
    // Signed bounds so a small expected count cannot wrap below zero.
    localparam longint LO2 = longint'(EXP_CNT2) - longint'(TOL);
    localparam longint HI2 = longint'(EXP_CNT2) + longint'(TOL);
    localparam longint LO3 = longint'(EXP_CNT3) - longint'(TOL);
    localparam longint HI3 = longint'(EXP_CNT3) + longint'(TOL);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitLock = 2'd1,
        StSettle   = 2'd2,
        StMeasure  = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        return (inc && (c != {CNT_W{1'b1}})) ? c + CNT_W'(1) : c;
    endfunction

    function automatic logic out_of_tol(input logic [CNT_W-1:0] c, input longint lo,
                                        input longint hi);
        longint v;
        v = longint'(c);
        return (v < lo) || (v > hi);
    endfunction

    logic [2:0]       lock_sync_q, c2_sync_q, c3_sync_q;
    logic             lock_s, lock_rise, c2_rise, c3_rise, lock_lost;
    state_e           state_q;
    logic [SET_W-1:0] settle_q;
    logic [WIN_W-1:0] win_q;
    logic [CNT_W-1:0] edge2_q, edge3_q, edge2_nxt, edge3_nxt;

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q <= '0;
            c2_sync_q   <= '0;
            c3_sync_q   <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[1:0], pll_lock};
            c2_sync_q   <= {c2_sync_q[1:0], clkout2};
            c3_sync_q   <= {c3_sync_q[1:0], clkout3};
        end
    end

    always_comb begin
        lock_s    = lock_sync_q[1];
        lock_rise = lock_sync_q[1] & ~lock_sync_q[2];
        c2_rise   = c2_sync_q[1] & ~c2_sync_q[2];
        c3_rise   = c3_sync_q[1] & ~c3_sync_q[2];
        lock_lost = ((state_q == StSettle) || (state_q == StMeasure)) && !lock_s;
        edge2_nxt = sat_inc(edge2_q, c2_rise);
        edge3_nxt = sat_inc(edge3_q, c3_rise);
    end

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            settle_q   <= '0;
            win_q      <= '0;
            edge2_q    <= '0;
            edge3_q    <= '0;
            cnt2       <= '0;
            cnt3       <= '0;
            meas_valid <= 1'b0;
            freq_err2  <= 1'b0;
            freq_err3  <= 1'b0;
            lock_err   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (lock_lost) begin
                lock_err <= 1'b1;
            end
            if (!meas_en) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: state_q <= StWaitLock;
                    StWaitLock: begin
                        if (lock_s) begin
                            state_q  <= StSettle;
                            settle_q <= '0;
                        end
                    end
                    StSettle: begin
                        if (!lock_s) begin
                            state_q <= StWaitLock;
                        end else if (settle_q == SET_LAST) begin
                            state_q <= StMeasure;
                            win_q   <= '0;
                            edge2_q <= '0;
                            edge3_q <= '0;
                        end else begin
                            settle_q <= settle_q + SET_W'(1);
                        end
                    end
                    StMeasure: begin
                        if (!lock_s) begin
                            state_q <= StWaitLock;
                        end else if (win_q == WIN_LAST) begin
                            // Latch includes an edge detected in the final window cycle.
                            cnt2       <= edge2_nxt;
                            cnt3       <= edge3_nxt;
                            edge2_q    <= '0;
                            edge3_q    <= '0;
                            win_q      <= '0;
                            meas_valid <= 1'b1;
                            if (out_of_tol(edge2_nxt, LO2, HI2)) freq_err2 <= 1'b1;
                            if (out_of_tol(edge3_nxt, LO3, HI3)) freq_err3 <= 1'b1;
                        end else begin
                            win_q   <= win_q + WIN_W'(1);
                            edge2_q <= edge2_nxt;
                            edge3_q <= edge3_nxt;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
            if (clr_err) begin
                freq_err2 <= 1'b0;
                freq_err3 <= 1'b0;
                lock_err  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            relock_cnt  <= '0;
            err_chk     <= 1'b0;
            results_cnt <= '0;
        end else if (clr_err) begin
            // err_chk is cleared too so a stale value cannot bump the tally after the clear.
            relock_cnt  <= '0;
            err_chk     <= 1'b0;
            results_cnt <= '0;
        end else begin
            if (lock_rise && (relock_cnt != 2'd3)) begin
                relock_cnt <= relock_cnt + 2'd1;
            end
            err_chk <= freq_err2 | freq_err3 | lock_err;
            if (results_cnt == 3'd7) begin
                results_cnt <= 3'd4;
            end else if (err_chk) begin
                results_cnt <= results_cnt + 3'd1;
            end
        end
    end

    assign state = state_q;

endmodule
